// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: datapath width, PC
// increment, FSM state encodings and an alignment helper.
package instruction_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_ERR  = 2'd2
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch_watchdog.sv
// Fetch watchdog: counts REQ cycles without an ack and flags expiry on the
// TIMEOUT_CYCLES-th such cycle. Only built when FETCH_TIMEOUT_EN is defined.
// Ports:
//   i_Clk, i_Rst  clock, synchronous active-high reset
//   i_Active      fetch FSM is in REQ
//   i_Ack         memory ack this cycle
//   o_Expired     combinational: this is the last permitted REQ cycle, no ack
`ifdef FETCH_TIMEOUT_EN
module instruction_fetch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Active,
  input  logic i_Ack,
  output logic o_Expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_Count;

  // Down-counter reloads whenever outside REQ (so it is fresh on entry)
  // and on every ack; terminal count at zero.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || !i_Active || i_Ack) begin
      r_Count <= LOAD_VAL;
    end else if (r_Count != '0) begin
      r_Count <= r_Count - 1'b1;
    end
  end

  assign o_Expired = i_Active && !i_Ack && (r_Count == '0);

endmodule
`endif

// File: rtl/instruction_fetch.sv
// Instruction fetch initiator. Owns the PC, issues word reads on the memory
// bus and bypasses returned words to the instruction register in the ack
// cycle. Handles branch/jump redirects, including redirects that arrive
// while a read is outstanding (the in-flight word is killed).
// Optional feature macro: FETCH_TIMEOUT_EN enables a bus watchdog that
// abandons a request after TIMEOUT_CYCLES unacknowledged REQ cycles.
// Ports:
//   i_Clk, i_Rst               clock, synchronous active-high reset
//   i_FetchReq                 control unit wants the next instruction
//   i_Redirect, i_RedirectPC   one-cycle redirect pulse and target
//   o_MemReq, o_MemAddr        read request / address (held until ack)
//   i_MemAck, i_MemData        read data valid / data
//   o_IrWr, o_IrData           instruction-register write strobe / data
//   o_PC                       current/next fetch address
//   o_Busy                     request in progress
//   o_FetchErr                 sticky misalignment / bus timeout error
//
// State table:
//   FETCH_IDLE | no request outstanding, waiting for i_FetchReq
//   FETCH_REQ  | o_MemReq high at r_PC, waiting for i_MemAck
//   FETCH_ERR  | faulted; only an aligned redirect or reset leaves
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
  input  logic            i_FetchReq,
  input  logic            i_Redirect,
  input  logic [XLEN-1:0] i_RedirectPC,
  output logic            o_MemReq,
  output logic [XLEN-1:0] o_MemAddr,
  input  logic            i_MemAck,
  input  logic [XLEN-1:0] i_MemData,
  output logic            o_IrWr,
  output logic [XLEN-1:0] o_IrData,
  output logic [XLEN-1:0] o_PC,
  output logic            o_Busy,
  output logic            o_FetchErr
);

  fetch_state_t    r_State, w_NextState;
  logic [XLEN-1:0] r_PC, w_NextPC;
  logic [XLEN-1:0] r_PendPC, w_NextPend;
  logic            r_Kill, w_NextKill;
  logic            r_FetchErr, w_NextErr;
  logic            w_IrWr;
  logic            w_Discard;
  logic [XLEN-1:0] w_Target;
  logic            w_Timeout;

`ifdef FETCH_TIMEOUT_EN
  instruction_fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Active (r_State == FETCH_REQ),
    .i_Ack    (i_MemAck),
    .o_Expired(w_Timeout)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign w_Timeout    = 1'b0;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State    <= FETCH_IDLE;
      r_PC       <= RESET_PC;
      r_PendPC   <= RESET_PC;
      r_Kill     <= 1'b0;
      r_FetchErr <= 1'b0;
    end else begin
      r_State    <= w_NextState;
      r_PC       <= w_NextPC;
      r_PendPC   <= w_NextPend;
      r_Kill     <= w_NextKill;
      r_FetchErr <= w_NextErr;
    end
  end

  // A fresh redirect in the ack cycle overrides any earlier pending one.
  always_comb begin
    w_Discard = 1'b0;
    w_Target  = r_PendPC;
    if (i_Redirect) begin
      w_Discard = 1'b1;
      w_Target  = i_RedirectPC;
    end else if (r_Kill) begin
      w_Discard = 1'b1;
    end
  end

  always_comb begin
    w_NextState = r_State;
    w_NextPC    = r_PC;
    w_NextPend  = r_PendPC;
    w_NextKill  = r_Kill;
    w_NextErr   = r_FetchErr;
    w_IrWr      = 1'b0;
    case (r_State)
      FETCH_IDLE: begin
        if (i_Redirect) begin
          w_NextPC = i_RedirectPC;
          if (!is_word_aligned(i_RedirectPC)) begin
            w_NextState = FETCH_ERR;
            w_NextErr   = 1'b1;
          end else if (i_FetchReq) begin
            w_NextState = FETCH_REQ;
          end
        end else if (i_FetchReq) begin
          w_NextState = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (i_MemAck) begin
          w_NextKill = 1'b0;
          if (w_Discard) begin
            w_NextPC = w_Target;
            if (!is_word_aligned(w_Target)) begin
              w_NextState = FETCH_ERR;
              w_NextErr   = 1'b1;
            end else begin
              w_NextState = i_FetchReq ? FETCH_REQ : FETCH_IDLE;
            end
          end else begin
            w_IrWr      = 1'b1;
            w_NextPC    = r_PC + PC_INC;
            w_NextState = i_FetchReq ? FETCH_REQ : FETCH_IDLE;
          end
        end else if (w_Timeout) begin
          w_NextState = FETCH_ERR;
          w_NextErr   = 1'b1;
          w_NextKill  = 1'b0;
        end else if (i_Redirect) begin
          // Address must stay stable until the outstanding read completes.
          w_NextKill = 1'b1;
          w_NextPend = i_RedirectPC;
        end
      end
      FETCH_ERR: begin
        if (i_Redirect) begin
          w_NextPC = i_RedirectPC;
          if (is_word_aligned(i_RedirectPC)) begin
            w_NextErr   = 1'b0;
            w_NextState = FETCH_IDLE;
          end
        end
      end
      default: w_NextState = FETCH_IDLE;
    endcase
  end

  assign o_MemReq   = (r_State == FETCH_REQ);
  assign o_MemAddr  = r_PC;
  assign o_IrWr     = w_IrWr;
  assign o_IrData   = i_MemData;
  assign o_PC       = r_PC;
  assign o_Busy     = (r_State == FETCH_REQ);
  assign o_FetchErr = r_FetchErr;

endmodule
